// File: rtl/matrix_scan_arbiter.sv
// matrix_scan_arbiter
//   Shares one 8x16 LED-matrix point drive between two point requesters.
//   Each granted point is held for DWELL cycles; grants alternate round-robin
//   on ties and the drive blanks (en=0) when nothing is pending.
//
// Ports
//   CLK            system clock, rising edge
//   RST            synchronous active-high reset
//   req0/x0/y0     requester 0 point request and coordinates
//   ack0           one-cycle accept pulse for requester 0
//   req1/x1/y1     requester 1 point request and coordinates
//   ack1           one-cycle accept pulse for requester 1
//   xOut/yOut      coordinates currently driven
//   en             matrix drive enable
//   grant          owner of the current/last point
//   busy           high while a point is being held
//
// state | meaning
// IDLE  | drive blanked, arbitrate every cycle
// HOLD  | point lit, dwell counter running; arbitrate on terminal count
module matrix_scan_arbiter #(
   parameter int unsigned DWELL = 10000,
   parameter int unsigned XW    = 3,
   parameter int unsigned YW    = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   output logic          ack0,
   input  logic          req1,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   output logic          ack1,
   output logic [XW-1:0] xOut,
   output logic [YW-1:0] yOut,
   output logic          en,
   output logic          grant,
   output logic          busy
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [19:0] TC = 20'(DWELL - 1);

   state_t        state_q, state_d;
   logic [19:0]   cnt_q, cnt_d;
   logic          prio_q, prio_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          grant_q, grant_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;

   logic arb_pt;
   logic win_k;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prio_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         grant_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         x_q     <= x_d;
         y_q     <= y_d;
         grant_q <= grant_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prio_d  = prio_q;
      x_d     = x_q;
      y_d     = y_q;
      grant_d = grant_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;

      arb_pt = (state_q == IDLE) || (cnt_q == TC);
      // Tie goes to prio; otherwise whichever single requester is high.
      win_k  = (req0 && req1) ? prio_q : req1;

      if (arb_pt) begin
         if (req0 || req1) begin
            state_d = HOLD;
            cnt_d   = '0;
            prio_d  = ~win_k;
            grant_d = win_k;
            x_d     = win_k ? x1 : x0;
            y_d     = win_k ? y1 : y0;
            ack0_d  = ~win_k;
            ack1_d  = win_k;
         end else begin
            // Coordinates and grant keep their last values; only en blanks.
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_q + 20'd1;
      end
   end

   assign xOut  = x_q;
   assign yOut  = y_q;
   assign grant = grant_q;
   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign en    = (state_q == HOLD);
   assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
module tb_matrix_scan_arbiter;

   localparam int unsigned DWELL = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] x0 = '0, x1 = '0;
   logic [3:0] y0 = '0, y1 = '0;
   logic       ack0, ack1, en, grant, busy;
   logic [2:0] xOut;
   logic [3:0] yOut;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       k;
      logic [2:0] x;
      logic [3:0] y;
   } exp_t;

   exp_t sb[$];

   matrix_scan_arbiter #(.DWELL(DWELL), .XW(3), .YW(4)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .x0(x0), .y0(y0), .ack0(ack0),
      .req1(req1), .x1(x1), .y1(y1), .ack1(ack1),
      .xOut(xOut), .yOut(yOut), .en(en), .grant(grant), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Every ack pops the next expected grant from the scoreboard.
   always @(negedge CLK) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
         checks++;
         if (ack0 === 1'b1 && ack1 === 1'b1) begin
            errors++;
            $display("FAIL ack_exclusive t=%0t ack0=%b ack1=%b required not both high", $time, ack0, ack1);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack t=%0t ack0=%b ack1=%b required no ack", $time, ack0, ack1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ack1 !== e.k || grant !== e.k || xOut !== e.x || yOut !== e.y || en !== 1'b1) begin
               errors++;
               $display("FAIL grant_point t=%0t got ack1=%b grant=%b x=%0d y=%0d en=%b required ack1=%b grant=%b x=%0d y=%0d en=1",
                        $time, ack1, grant, xOut, yOut, en, e.k, e.k, e.x, e.y);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         x0 = 3'($urandom); y0 = 4'($urandom);
         x1 = 3'($urandom); y1 = 4'($urandom);
         tick();
         checks++;
         if ({xOut, yOut, en, busy, grant, ack0, ack1} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got x=%0d y=%0d en=%b busy=%b grant=%b ack0=%b ack1=%b required all 0",
                     i, xOut, yOut, en, busy, grant, ack0, ack1);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      RST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_blank cyc=%0d got en=%b busy=%b required 0/0", i, en, busy);
         end
      end
   endtask

   task automatic test_single();
      req0 = 1'b1; x0 = 3'd5; y0 = 4'd12;
      sb.push_back('{k: 1'b0, x: 3'd5, y: 4'd12});
      for (int j = 1; j <= DWELL; j++) begin
         tick();
         checks++;
         if (en !== 1'b1 || busy !== 1'b1 || xOut !== 3'd5 || yOut !== 4'd12 || grant !== 1'b0) begin
            errors++;
            $display("FAIL single_hold j=%0d got en=%b busy=%b x=%0d y=%0d grant=%b required 1/1/5/12/0",
                     j, en, busy, xOut, yOut, grant);
         end
         if (j == 2) begin
            checks++;
            if (ack0 !== 1'b0) begin
               errors++;
               $display("FAIL single_ack_width got ack0=%b required 0 on second cycle", ack0);
            end
         end
         if (j == 1) req0 = 1'b0;
      end
      tick();
      checks++;
      if (en !== 1'b0 || busy !== 1'b0 || xOut !== 3'd5 || yOut !== 4'd12) begin
         errors++;
         $display("FAIL single_release got en=%b busy=%b x=%0d y=%0d required 0/0/5/12", en, busy, xOut, yOut);
      end
   endtask

   task automatic test_tie();
      logic [2:0] xs[4];
      logic [2:0] ex;
      logic       eg;
      xs[0] = 3'd1; xs[1] = 3'd6; xs[2] = 3'd2; xs[3] = 3'd7;
      RST = 1'b1;
      req0 = 1'b1; x0 = 3'd1; y0 = 4'd2;
      req1 = 1'b1; x1 = 3'd6; y1 = 4'd9;
      tick();
      RST = 1'b0;
      sb.push_back('{k: 1'b0, x: 3'd1, y: 4'd2});
      sb.push_back('{k: 1'b1, x: 3'd6, y: 4'd9});
      sb.push_back('{k: 1'b0, x: 3'd2, y: 4'd2});
      sb.push_back('{k: 1'b1, x: 3'd7, y: 4'd9});
      for (int j = 1; j <= 4 * DWELL; j++) begin
         tick();
         ex = xs[(j - 1) / DWELL];
         eg = 1'(((j - 1) / DWELL) % 2);
         checks++;
         if (en !== 1'b1 || grant !== eg || xOut !== ex) begin
            errors++;
            $display("FAIL tie_stream j=%0d got en=%b grant=%b x=%0d required en=1 grant=%b x=%0d",
                     j, en, grant, xOut, eg, ex);
         end
         if (j == 1) x0 = 3'd2;
         if (j == 1 + DWELL) x1 = 3'd7;
         if (j == 4 * DWELL) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
      tick();
      checks++;
      if (en !== 1'b0) begin
         errors++;
         $display("FAIL tie_end got en=%b required 0", en);
      end
   endtask

   task automatic test_freeze();
      req0 = 1'b1; x0 = 3'd3; y0 = 4'd4;
      sb.push_back('{k: 1'b0, x: 3'd3, y: 4'd4});
      for (int j = 1; j <= DWELL; j++) begin
         tick();
         checks++;
         if (xOut !== 3'd3 || yOut !== 4'd4 || en !== 1'b1) begin
            errors++;
            $display("FAIL freeze_coords j=%0d got x=%0d y=%0d en=%b required 3/4/1", j, xOut, yOut, en);
         end
         if (j == 1) begin
            req0 = 1'b0; x0 = 3'd7; y0 = 4'd15; req1 = 1'b1; x1 = 3'd1; y1 = 4'd1;
         end
         if (j == 2) req1 = 1'b0;
         if (j == 3) begin
            req1 = 1'b1; x1 = 3'd2; y1 = 4'd11;
            sb.push_back('{k: 1'b1, x: 3'd2, y: 4'd11});
         end
      end
      tick();
      checks++;
      if (grant !== 1'b1 || xOut !== 3'd2 || yOut !== 4'd11 || en !== 1'b1) begin
         errors++;
         $display("FAIL freeze_terminal_req got grant=%b x=%0d y=%0d en=%b required 1/2/11/1", grant, xOut, yOut, en);
      end
      req1 = 1'b0;
      for (int j = 0; j < DWELL; j++) tick();
      checks++;
      if (en !== 1'b0) begin
         errors++;
         $display("FAIL freeze_end got en=%b required 0", en);
      end
   endtask

   task automatic test_reset_mid();
      req0 = 1'b1; x0 = 3'd4; y0 = 4'd4;
      req1 = 1'b1; x1 = 3'd5; y1 = 4'd5;
      sb.push_back('{k: 1'b0, x: 3'd4, y: 4'd4});
      tick();
      tick();
      RST = 1'b1;
      tick();
      checks++;
      if (en !== 1'b0 || busy !== 1'b0 || xOut !== 3'd0 || yOut !== 4'd0 || grant !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got en=%b busy=%b x=%0d y=%0d grant=%b required all 0", en, busy, xOut, yOut, grant);
      end
      RST = 1'b0;
      sb.push_back('{k: 1'b0, x: 3'd4, y: 4'd4});
      tick();
      checks++;
      if (grant !== 1'b0 || en !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_prio got grant=%b en=%b required 0/1", grant, en);
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int j = 0; j < DWELL; j++) tick();
   endtask

   task automatic test_withdraw();
      req0 = 1'b1; x0 = 3'd1; y0 = 4'd1;
      sb.push_back('{k: 1'b0, x: 3'd1, y: 4'd1});
      tick();
      x0 = 3'd2; y0 = 4'd3;
      req1 = 1'b1; x1 = 3'd6; y1 = 4'd6;
      sb.push_back('{k: 1'b0, x: 3'd2, y: 4'd3});
      tick();
      tick();
      req1 = 1'b0;
      tick();
      tick();
      checks++;
      if (grant !== 1'b0 || xOut !== 3'd2 || yOut !== 4'd3 || en !== 1'b1) begin
         errors++;
         $display("FAIL withdraw_owner got grant=%b x=%0d y=%0d en=%b required 0/2/3/1", grant, xOut, yOut, en);
      end
      req0 = 1'b0;
      for (int j = 0; j < DWELL; j++) tick();
      checks++;
      if (en !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_idle got en=%b required 0", en);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_freeze();
      test_reset_mid();
      test_withdraw();
      for (int j = 0; j < 4; j++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending grants required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matrix_scan_arbiter.md
# matrix_scan_arbiter

Shares the single 8x16 LED-matrix point drive (column xOut, row yOut) between two point-producing requesters, e.g. the falling-box game layer and a score/overlay layer. Each granted point is held on the matrix for a fixed dwell time, then the drive moves to the next request. Requests are served round-robin, and the drive is blanked when no request is pending. The block sits between the game/overlay sequencers and the matrix pin drivers, and replaces per-layer prescalers with one shared dwell counter.

## Interface
- DWELL, 10000: cycles each granted point is driven; legal range 2..2^20-1
- XW, 3: column coordinate width
- YW, 4: row coordinate width
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 point request; held high with x0/y0 stable until ack0
- x0  in  XW  requester 0 column
- y0  in  YW  requester 0 row
- ack0  out  1  one-cycle pulse: requester 0 point accepted
- req1, x1, y1, ack1: same meaning and widths for requester 1
- xOut  out  XW  column currently driven
- yOut  out  YW  row currently driven
- en  out  1  matrix drive enable (1 = point lit)
- grant  out  1  index of the requester owning the current point
- busy  out  1  1 while a point is being held (state HOLD)

## Operation
- FSM states: IDLE, HOLD. The dwell counter is 20 bits wide, counts 0..DWELL-1, and is cleared on every grant.
- Arbitration point: every cycle in IDLE, or the terminal-count cycle in HOLD (count == DWELL-1).
- At an arbitration point:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester selected by the priority pointer `prio` wins.
  - After a win by k, `prio` is set to the other requester (!k).
- Win by k:
  - Next edge: xOut/yOut capture xk/yk, grant=k, en=1, busy=1, ackk=1 for exactly one cycle, counter=0, state=HOLD.
- No request at an arbitration point:
  - In IDLE: stay in IDLE.
  - In HOLD at terminal count: next edge goes to IDLE with en=0, busy=0.
  - xOut, yOut and grant hold their last values; only en blanks.
- HOLD, non-terminal cycles:
  - req inputs are ignored.
  - xOut/yOut stay frozen even if x/y inputs change.
- Requester protocol:
  - After seeing ackk, the requester either drops reqk or presents its next point with reqk still high.
  - A req still high at the next arbitration point is treated as a new request. This gives streaming.
  - A req dropped before ack is a withdrawn request and is never acknowledged.
- ack0 and ack1 are never high in the same cycle. An ack is never issued without a req having been high in the preceding cycle.
- Reset value of `prio` is 0, so requester 0 wins the first tie.

## Timing
- Reset values (outputs and state):
  - xOut=0, yOut=0, en=0, busy=0, grant=0, ack0=0, ack1=0
  - prio=0, counter=0, state=IDLE
- Reset mid-HOLD: the point is aborted at the next edge and en drops. No ack is issued for requests pending in the reset cycle.
- Latency:
  - A req rising in IDLE at cycle t produces ack, en=1 and new xOut/yOut at edge t+1 (registered, 1 cycle).
- Dwell:
  - en stays high, with constant coordinates, for exactly DWELL cycles per point.
  - Back-to-back grants have no blank cycle: the coordinate change and ack coincide with the edge that would otherwise end the dwell.
- Throughput: one point per DWELL cycles. With both requesters streaming they alternate 0,1,0,1...
- Simultaneous events:
  - Terminal count with both reqs high: the winner follows prio.
  - A req dropping in the same cycle as its arbitration point is treated as not requesting.
- Arithmetic: the counter compares against DWELL-1 at full 20-bit width and never wraps past DWELL-1.

## Test plan
- Reset: RST=1 for 3 cycles with random requests → all outputs 0, no acks. RST=0 with no req → en stays 0 indefinitely.
- Single request (DWELL=4): req0 high at cycle 10 with x0=5, y0=12 → ack0 pulse at cycle 11; xOut=5, yOut=12, en=1, grant=0 for cycles 11–14; req0 dropped after ack → en=0 at cycle 15, xOut/yOut still 5/12.
- Tie after reset (DWELL=4): req0 and req1 both high at cycle 10, both held → grant sequence 0,1,0,1 with acks at cycles 11, 15, 19, 23 and no cycle with en=0.
- Input freeze: during a HOLD, change x0/y0 and toggle req1 on non-terminal cycles → xOut/yOut unchanged; no ack1 unless req1 is high at the terminal-count cycle.
- Reset mid-dwell: both requesters streaming, assert RST at dwell count 2 → next edge en=0, prio=0; after release requester 0 is granted first.
- Withdrawal: req1 high during HOLD of requester 0 but dropped before terminal count → no ack1; next owner is requester 0 if req0 is high, otherwise IDLE.
